// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and default width.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/serial_sub16_fs_cell.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit position must borrow.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial subtractor, LSB first: diff = a - b - bin over WIDTH clocks with start/busy/done handshake.
//   state  | meaning
//   IDLE   | waiting for start; operands captured on accept
//   RUN    | one bit per clock through the full subtractor
//   DONE   | one-cycle done pulse; results already registered
import serial_sub_pkg::*;

module serial_sub16 #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic             d_bit;
  logic             bo_bit;
  logic             last;

  fs_cell u_fs_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Results are written on the edge that processes the MSB so they are valid during the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= bo_bit;
          res  <= {d_bit, res[WIDTH-1:1]};
          if (last) begin
            diff <= {d_bit, res[WIDTH-1:1]};
            bout <= bo_bit;
            ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: directed cases, random operands, stray starts and mid-run reset.
module tb_serial_sub16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int n_assert = 0;
  int n_fail   = 0;

  serial_sub16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for the borrow and signed for overflow.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] md, output logic mbo, output logic mov);
    int u;
    int s;
    u   = int'(ma) - int'(mb) - int'(mbin);
    s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md  = u[15:0];
    mbo = (u < 0);
    mov = (s > 32767) || (s < -32768);
  endtask

  // Runs one operation; stray1/stray2 are cycles in which start is raised again and must be ignored.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tbin, input int stray1, input int stray2);
    logic [15:0] ed;
    logic        ebo;
    logic        eov;
    logic [15:0] prev_diff;
    int          lat;
    bit          seen;
    model(ta, tb, tbin, ed, ebo, eov);
    prev_diff = diff;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      if (lat > 0) begin
        @(posedge clk);
        #1;
      end
      lat++;
      start = (lat == stray1 || lat == stray2);
      if (done) seen = 1;
      else if (lat <= 16) begin
        if (!busy) chk({tag, " busy"}, 32'(busy), 32'd1);
        if (lat == 8) chk({tag, " diff_hold"}, 32'(diff), 32'(prev_diff));
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd17);
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(ebo));
    chk({tag, " ovf"}, 32'(ovf), 32'(eov));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " done_single"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;
    int          lat;
    bit          seen_done;

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("t1", 16'h0003, 16'h0002, 1'b0, 0, 0);
    chk("t1 exact diff", 32'(diff), 32'h0001);
    do_op("t2", 16'h0007, 16'h0023, 1'b0, 0, 0);
    chk("t2 exact diff", 32'(diff), 32'hFFE4);
    do_op("t3", 16'h0003, 16'h1003, 1'b1, 0, 0);
    chk("t3 exact diff", 32'(diff), 32'hEFFF);
    do_op("t4a", 16'hFFFF, 16'hFFFF, 1'b0, 0, 0);
    do_op("t4b", 16'h8000, 16'h0001, 1'b0, 0, 0);
    chk("t4b exact ovf", 32'(ovf), 32'd1);
    do_op("t4c", 16'h7FFF, 16'hFFFF, 1'b0, 0, 0);
    do_op("t4d", 16'h0000, 16'h0000, 1'b1, 0, 0);
    do_op("t5 stray", 16'h1234, 16'h0F0F, 1'b0, 5, 17);

    for (int i = 0; i < 10; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      do_op("rand", ra, rb, rbin, 0, 0);
    end

    // Reset in the middle of RUN aborts the operation with no done pulse.
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    seen_done = 0;
    while (lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen_done = 1;
    end
    rst_n = 1'b0;
    #1;
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 diff", 32'(diff), 32'd0);
    chk("t6 bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1;
    end
    chk("t6 no_done", 32'(seen_done), 32'd0);
    do_op("t6 after", 16'h5555, 16'h1111, 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
